// File: rtl/eth_arb_pkg.sv
// Shared types and the round-robin search used by the MAC transmit arbiter.
package eth_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DROP = 2'd2
   } arb_state_t;

   localparam int MAX_SRC = 8;

   // First set bit of req searching upward from last+1, wrapping at num.
   function automatic logic [2:0] rr_next(input logic [7:0] req,
                                          input logic [2:0] last,
                                          input logic [3:0] num);
      logic [2:0] pick;
      logic       found;
      logic [3:0] cand;
      pick  = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= MAX_SRC; k++) begin
         cand = {1'b0, last} + 4'(k);
         if (cand >= num) begin
            cand = cand - num;
         end else begin
            cand = cand;
         end
         if (!found && (4'(k) <= num) && req[cand[2:0]]) begin
            pick  = cand[2:0];
            found = 1'b1;
         end else begin
            pick  = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker over NUM_SRC requesters.
module rr_pick
   import eth_arb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int IW      = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IW-1:0]      last,
   output logic [IW-1:0]      idx,
   output logic               any
);

   logic [2:0] w_pick;

   assign w_pick = rr_next(8'(req), 3'(last), 4'(NUM_SRC));
   assign idx    = IW'(w_pick);
   assign any    = |req;

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the MAC user transmit stream.
// Oversize packets are cut at MAX_WORDS and the rest of the source packet is drained.
module axis_tx_arbiter
   import eth_arb_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int MAX_WORDS = 384
) (
   input  logic                        Clk_user,
   input  logic                        Reset_n,
   input  logic                        CPU_init_end,
   input  logic [32*NUM_SRC-1:0]       In_AXIS_tdata,
   input  logic [4*NUM_SRC-1:0]        In_AXIS_tstrb,
   input  logic [NUM_SRC-1:0]          In_AXIS_tlast,
   input  logic [NUM_SRC-1:0]          In_AXIS_tvalid,
   output logic [NUM_SRC-1:0]          In_AXIS_tready,
   output logic [31:0]                 S_AXIS_tdata,
   output logic [3:0]                  S_AXIS_tstrb,
   output logic                        S_AXIS_tlast,
   output logic                        S_AXIS_tvalid,
   input  logic                        S_AXIS_tready,
   output logic                        S_AXIS_tdest,
   output logic                        S_AXIS_tid,
   output logic [$clog2(NUM_SRC)-1:0]  Grant_idx,
   output logic                        Busy,
   output logic                        Trunc_pulse,
   output logic [16*NUM_SRC-1:0]       Pkt_cnt
);

   localparam int IW = $clog2(NUM_SRC);
   localparam int CW = $clog2(MAX_WORDS + 1);

   arb_state_t      r_state;
   arb_state_t      w_state_nxt;
   logic [IW-1:0]   r_grant;
   logic [IW-1:0]   r_last_grant;
   logic [CW-1:0]   r_word_cnt;
   logic            r_trunc;
   logic [15:0]     r_pkt_cnt [NUM_SRC];

   logic [31:0]     w_tdata [NUM_SRC];
   logic [3:0]      w_tstrb [NUM_SRC];
   logic [IW-1:0]   w_pick;
   logic            w_any;
   logic            w_go;
   logic            w_src_valid;
   logic            w_src_last;
   logic            w_limit;
   logic            w_xfer_acc;
   logic            w_pkt_end;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign w_tdata[gi]             = In_AXIS_tdata[32*gi +: 32];
         assign w_tstrb[gi]             = In_AXIS_tstrb[4*gi +: 4];
         assign Pkt_cnt[16*gi +: 16]    = r_pkt_cnt[gi];
      end
   endgenerate

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IW      (IW)
   ) u_rr_pick (
      .req  (In_AXIS_tvalid),
      .last (r_last_grant),
      .idx  (w_pick),
      .any  (w_any)
   );

   assign w_go        = CPU_init_end & w_any;
   assign w_src_valid = In_AXIS_tvalid[r_grant];
   assign w_src_last  = In_AXIS_tlast[r_grant];
   assign w_limit     = (r_word_cnt == CW'(MAX_WORDS - 1));
   assign w_xfer_acc  = (r_state == XFER) & w_src_valid & S_AXIS_tready;
   // The limit beat closes the packet even when the source has more to send.
   assign w_pkt_end   = w_xfer_acc & (w_src_last | w_limit);

   assign Grant_idx    = r_grant;
   assign Busy         = (r_state != IDLE);
   assign Trunc_pulse  = r_trunc;
   assign S_AXIS_tdest = 1'b0;
   assign S_AXIS_tid   = 1'b0;

   // State register.
   always_ff @(posedge Clk_user or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_go) w_state_nxt = XFER;
            else      w_state_nxt = IDLE;
         end
         XFER: begin
            if (w_pkt_end) w_state_nxt = w_src_last ? IDLE : DROP;
            else           w_state_nxt = XFER;
         end
         DROP: begin
            if (w_src_valid && w_src_last) w_state_nxt = IDLE;
            else                           w_state_nxt = DROP;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Stream mux and ready steering; valid never looks at S_AXIS_tready.
   always_comb begin
      S_AXIS_tdata   = w_tdata[r_grant];
      S_AXIS_tstrb   = w_tstrb[r_grant];
      S_AXIS_tvalid  = 1'b0;
      S_AXIS_tlast   = 1'b0;
      In_AXIS_tready = {NUM_SRC{1'b0}};
      case (r_state)
         XFER: begin
            S_AXIS_tvalid           = w_src_valid;
            S_AXIS_tlast            = w_src_last | w_limit;
            In_AXIS_tready[r_grant] = S_AXIS_tready;
         end
         DROP: begin
            In_AXIS_tready[r_grant] = 1'b1;
         end
         default: begin
            S_AXIS_tvalid = 1'b0;
         end
      endcase
   end

   // Grant, beat counter, packet counters and truncation pulse.
   always_ff @(posedge Clk_user or negedge Reset_n) begin
      if (!Reset_n) begin
         r_grant      <= {IW{1'b0}};
         r_last_grant <= IW'(NUM_SRC - 1);
         r_word_cnt   <= {CW{1'b0}};
         r_trunc      <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_pkt_cnt[i] <= 16'd0;
         end
      end else begin
         r_trunc <= w_pkt_end & ~w_src_last;
         if ((r_state == IDLE) && w_go) begin
            r_grant    <= w_pick;
            r_word_cnt <= {CW{1'b0}};
         end else if (w_xfer_acc) begin
            r_word_cnt <= r_word_cnt + CW'(1);
         end
         if (w_pkt_end) begin
            r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 16'd1;
            r_last_grant       <= r_grant;
         end
      end
   end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Randomized bench for axis_tx_arbiter against a packet-level round-robin model.
module tb_axis_tx_arbiter;

   localparam int NS = 4;
   localparam int MW = 8;

   logic              clk = 1'b0;
   logic              Reset_n;
   logic              CPU_init_end;
   logic [32*NS-1:0]  In_AXIS_tdata;
   logic [4*NS-1:0]   In_AXIS_tstrb;
   logic [NS-1:0]     In_AXIS_tlast;
   logic [NS-1:0]     In_AXIS_tvalid;
   logic [NS-1:0]     In_AXIS_tready;
   logic [31:0]       S_AXIS_tdata;
   logic [3:0]        S_AXIS_tstrb;
   logic              S_AXIS_tlast;
   logic              S_AXIS_tvalid;
   logic              S_AXIS_tready;
   logic              S_AXIS_tdest;
   logic              S_AXIS_tid;
   logic [1:0]        Grant_idx;
   logic              Busy;
   logic              Trunc_pulse;
   logic [16*NS-1:0]  Pkt_cnt;

   always #5 clk = ~clk;

   axis_tx_arbiter #(.NUM_SRC(NS), .MAX_WORDS(MW)) dut (
      .Clk_user       (clk),
      .Reset_n        (Reset_n),
      .CPU_init_end   (CPU_init_end),
      .In_AXIS_tdata  (In_AXIS_tdata),
      .In_AXIS_tstrb  (In_AXIS_tstrb),
      .In_AXIS_tlast  (In_AXIS_tlast),
      .In_AXIS_tvalid (In_AXIS_tvalid),
      .In_AXIS_tready (In_AXIS_tready),
      .S_AXIS_tdata   (S_AXIS_tdata),
      .S_AXIS_tstrb   (S_AXIS_tstrb),
      .S_AXIS_tlast   (S_AXIS_tlast),
      .S_AXIS_tvalid  (S_AXIS_tvalid),
      .S_AXIS_tready  (S_AXIS_tready),
      .S_AXIS_tdest   (S_AXIS_tdest),
      .S_AXIS_tid     (S_AXIS_tid),
      .Grant_idx      (Grant_idx),
      .Busy           (Busy),
      .Trunc_pulse    (Trunc_pulse),
      .Pkt_cnt        (Pkt_cnt)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
      logic        f;
   } beat_t;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
      logic        t;
      logic        f;
      logic [1:0]  src;
   } exp_t;

   beat_t       srcq [NS][$];
   exp_t        expq [$];
   int          checks;
   int          failures;
   int          m_last;
   int          m_trunc;
   logic [15:0] m_pkt [NS];
   int          n_trunc;
   int          n_out;
   bit          held [NS];
   int          mode;
   bit          gaps;
   bit          cpu_rand;
   bit          tog;
   bit          prev_stall;
   logic [36:0] prev_beat;
   bit          prev_last;
   bit          prev_t;
   bit          busy_s;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic add_pkt(input int src, input int len, input bit pattern);
      beat_t b;
      for (int k = 1; k <= len; k++) begin
         b.d = pattern ? 32'(32'h11111111 * k) : 32'($urandom);
         b.s = pattern ? 4'hF : 4'($urandom_range(0, 15));
         b.l = (k == len);
         b.f = (k == 1);
         srcq[src].push_back(b);
      end
   endtask

   // Packet-level model: round robin over sources with queued packets,
   // each packet cut to MW beats with the last one flagged.
   task automatic build_expected();
      beat_t cp [NS][$];
      beat_t b;
      exp_t  e;
      int    s;
      int    n;
      bit    found;
      bit    done;
      for (int i = 0; i < NS; i++) cp[i] = srcq[i];
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         s = 0;
         for (int k = 1; k <= NS; k++) begin
            if (!found && cp[(m_last + k) % NS].size() > 0) begin
               s = (m_last + k) % NS;
               found = 1'b1;
            end
         end
         if (found) begin
            n = 0;
            done = 1'b0;
            while (!done) begin
               b = cp[s].pop_front();
               n++;
               if (n <= MW) begin
                  e.d = b.d;
                  e.s = b.s;
                  e.l = b.l || (n == MW);
                  e.t = !b.l && (n == MW);
                  e.f = (n == 1);
                  e.src = 2'(s);
                  expq.push_back(e);
                  if (e.t) m_trunc++;
               end
               done = b.l;
            end
            m_pkt[s] = m_pkt[s] + 16'd1;
            m_last = s;
         end
      end
   endtask

   task automatic cycle();
      logic [NS-1:0] v;
      logic [NS-1:0] in_hs;
      bit            out_hs;
      exp_t          e;
      for (int i = 0; i < NS; i++) begin
         if (srcq[i].size() > 0) begin
            if (held[i] || srcq[i][0].f || !gaps) v[i] = 1'b1;
            else v[i] = ($urandom_range(0, 2) != 0);
            In_AXIS_tdata[32*i +: 32] = srcq[i][0].d;
            In_AXIS_tstrb[4*i +: 4]   = srcq[i][0].s;
            In_AXIS_tlast[i]          = srcq[i][0].l;
         end else begin
            v[i] = 1'b0;
            In_AXIS_tdata[32*i +: 32] = 32'd0;
            In_AXIS_tstrb[4*i +: 4]   = 4'd0;
            In_AXIS_tlast[i]          = 1'b0;
         end
      end
      In_AXIS_tvalid = v;
      case (mode)
         0: S_AXIS_tready = 1'b1;
         1: begin tog = ~tog; S_AXIS_tready = tog; end
         default: S_AXIS_tready = ($urandom_range(0, 1) != 0);
      endcase
      if (cpu_rand) CPU_init_end = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      in_hs  = In_AXIS_tvalid & In_AXIS_tready;
      out_hs = S_AXIS_tvalid & S_AXIS_tready;
      busy_s = Busy;
      if (Trunc_pulse) n_trunc++;
      if (prev_last) begin
         chk("gap_valid", 64'(S_AXIS_tvalid), 64'd0);
         if (!prev_t) chk("gap_idle", 64'(Busy), 64'd0);
      end
      if (prev_stall) begin
         chk("hold_valid", 64'(S_AXIS_tvalid), 64'd1);
         chk("hold_beat", 64'({S_AXIS_tdata, S_AXIS_tstrb, S_AXIS_tlast}), 64'(prev_beat));
      end
      prev_last = 1'b0;
      if (out_hs) begin
         n_out++;
         chk("beat_expected", 64'(expq.size() > 0), 64'd1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("data", 64'(S_AXIS_tdata), 64'(e.d));
            chk("strb", 64'(S_AXIS_tstrb), 64'(e.s));
            chk("last", 64'(S_AXIS_tlast), 64'(e.l));
            if (e.f) chk("grant", 64'(Grant_idx), 64'(e.src));
            prev_last = e.l;
            prev_t    = e.t;
         end
      end
      prev_stall = S_AXIS_tvalid & ~S_AXIS_tready;
      prev_beat  = {S_AXIS_tdata, S_AXIS_tstrb, S_AXIS_tlast};
      for (int i = 0; i < NS; i++) held[i] = In_AXIS_tvalid[i] & ~In_AXIS_tready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) if (in_hs[i]) void'(srcq[i].pop_front());
   endtask

   function automatic bit all_empty();
      bit r;
      r = (expq.size() == 0);
      for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) r = 1'b0;
      return r;
   endfunction

   task automatic run_done(input int budget);
      int c;
      bit done;
      c = 0;
      done = 1'b0;
      while (!done && c < budget) begin
         cycle();
         c++;
         done = all_empty() && !busy_s;
      end
      chk("drain_done", 64'(done), 64'd1);
      for (int i = 0; i < NS; i++) chk("pkt_cnt", 64'(Pkt_cnt[16*i +: 16]), 64'(m_pkt[i]));
      chk("trunc_cnt", 64'(n_trunc), 64'(m_trunc));
   endtask

   task automatic clear_bench();
      for (int i = 0; i < NS; i++) begin
         srcq[i].delete();
         held[i] = 1'b0;
         m_pkt[i] = 16'd0;
      end
      expq.delete();
      prev_stall = 1'b0;
      prev_last  = 1'b0;
      prev_t     = 1'b0;
      m_last     = NS - 1;
      m_trunc    = 0;
      n_trunc    = 0;
   endtask

   initial begin
      int start;
      int c;
      bit busy_seen;
      logic [NS-1:0] ready_seen;
      checks = 0;
      failures = 0;
      n_out = 0;
      mode = 0;
      gaps = 1'b0;
      cpu_rand = 1'b0;
      tog = 1'b0;
      busy_s = 1'b0;
      prev_beat = 37'd0;
      clear_bench();
      Reset_n = 1'b0;
      CPU_init_end = 1'b0;
      In_AXIS_tdata = '0;
      In_AXIS_tstrb = '0;
      In_AXIS_tlast = '0;
      In_AXIS_tvalid = '0;
      S_AXIS_tready = 1'b0;
      #22;
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_tvalid", 64'(S_AXIS_tvalid), 64'd0);
      chk("rst_ready", 64'(In_AXIS_tready), 64'd0);
      chk("rst_grant", 64'(Grant_idx), 64'd0);
      chk("rst_pkt", Pkt_cnt, 64'd0);
      chk("rst_trunc", 64'(Trunc_pulse), 64'd0);
      Reset_n = 1'b1;
      @(posedge clk);
      #1;
      CPU_init_end = 1'b1;

      // single source, fixed pattern
      add_pkt(0, 4, 1'b1);
      build_expected();
      run_done(200);

      // all sources requesting back to back
      for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) add_pkt(s, 2, 1'b0);
      build_expected();
      run_done(400);

      // oversize packet, then exact-length packet
      add_pkt(2, 12, 1'b0);
      build_expected();
      run_done(200);
      add_pkt(1, MW, 1'b0);
      build_expected();
      run_done(200);

      // configuration gate holds off grants
      CPU_init_end = 1'b0;
      for (int s = 0; s < NS; s++) add_pkt(s, $urandom_range(1, 10), 1'b0);
      busy_seen = 1'b0;
      ready_seen = '0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         busy_seen = busy_seen | busy_s;
         ready_seen = ready_seen | In_AXIS_tready;
      end
      chk("gate_busy", 64'(busy_seen), 64'd0);
      chk("gate_ready", 64'(ready_seen), 64'd0);
      build_expected();
      CPU_init_end = 1'b1;
      run_done(600);

      // toggling backpressure with source gaps
      mode = 1;
      gaps = 1'b1;
      for (int r = 0; r < 3; r++) for (int s = 0; s < NS; s++) add_pkt(s, $urandom_range(1, 12), 1'b0);
      build_expected();
      run_done(3000);

      // random ready, random config gate, random source subsets
      mode = 2;
      cpu_rand = 1'b1;
      for (int it = 0; it < 6; it++) begin
         for (int s = 0; s < NS; s++)
            if ($urandom_range(0, 2) != 0)
               for (int r = 0; r < $urandom_range(1, 3); r++) add_pkt(s, $urandom_range(1, 12), 1'b0);
         build_expected();
         run_done(4000);
      end
      cpu_rand = 1'b0;
      CPU_init_end = 1'b1;

      // asynchronous reset in the middle of a packet
      mode = 0;
      gaps = 1'b0;
      add_pkt(0, 6, 1'b0);
      build_expected();
      start = n_out;
      c = 0;
      while ((n_out - start) < 2 && c < 100) begin
         cycle();
         c++;
      end
      chk("pre_rst_beats", 64'(n_out - start), 64'd2);
      #3;
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 64'(S_AXIS_tvalid), 64'd0);
      chk("mid_rst_ready", 64'(In_AXIS_tready), 64'd0);
      chk("mid_rst_busy", 64'(Busy), 64'd0);
      chk("mid_rst_grant", 64'(Grant_idx), 64'd0);
      chk("mid_rst_pkt", Pkt_cnt, 64'd0);
      chk("mid_rst_trunc", 64'(Trunc_pulse), 64'd0);
      clear_bench();
      @(posedge clk);
      @(posedge clk);
      #2;
      Reset_n = 1'b1;
      add_pkt(3, 4, 1'b0);
      add_pkt(0, 3, 1'b0);
      build_expected();
      run_done(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
